qcmd_capture: RTL and testbench

Capture/readback block at the receiving end of the sequencer command stream (command, cmda, cstrobe, extra). Each strobed command is time-stamped relative to the last trig and stored in an on-chip buffer. The host reads the buffer back through a word-addressed port that uses the same 4-word-per-entry layout the generator is loaded with. Used for loopback verification of sequences and for post-run command logging.

---
 rtl/qcmd_capture_if.sv | 37 +++
 rtl/qcmd_capture.sv | 109 ++++++++++
 tb/tb_qcmd_capture.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qcmd_capture_if.sv
// Command-stream and host-readback signal bundle for qcmd_capture.
// QCMD_CAPTURE_FILTER_EN adds the cmda_mask/cmda_match filter inputs.
interface qcmd_capture_if #(
    parameter int unsigned aw = 15
);
    logic          trig;
    logic          cstrobe;
    logic [63:0]   command;
    logic [7:0]    cmda;
    logic [31:0]   extra;
    logic [aw-1:0] raddr;
    logic [31:0]   rdata;
    logic [aw-2:0] ncap;
    logic          overflow;
    logic          armed;
`ifdef QCMD_CAPTURE_FILTER_EN
    logic [7:0]    cmda_mask;
    logic [7:0]    cmda_match;
`endif

    // master drives the command stream and host address; slave is the capture block
    modport master (
        output trig, cstrobe, command, cmda, extra, raddr,
`ifdef QCMD_CAPTURE_FILTER_EN
        output cmda_mask, cmda_match,
`endif
        input  rdata, ncap, overflow, armed
    );

    modport slave (
        input  trig, cstrobe, command, cmda, extra, raddr,
`ifdef QCMD_CAPTURE_FILTER_EN
        input  cmda_mask, cmda_match,
`endif
        output rdata, ncap, overflow, armed
    );
endinterface

// File: rtl/qcmd_capture.sv
// Time-stamped capture of the sequencer command stream with 4-word-per-entry host readback.
// Optional QCMD_CAPTURE_FILTER_EN restricts capture to cmda values matching mask/match.
module qcmd_capture #(
    parameter int unsigned aw = 15,
    parameter int unsigned tw = 24
) (
    input  logic           clk,
    input  logic           rst,
    qcmd_capture_if.slave  bus
);
    localparam int unsigned   N     = 2 ** (aw - 2);
    localparam logic [aw-2:0] NFULL = (aw - 1)'(N);

    logic [tw-1:0] r_ts;
    logic [aw-3:0] r_wptr;
    logic [aw-2:0] r_ncap;
    logic          r_overflow;
    logic          r_armed;

    logic [31:0]   r_ram0 [N];
    logic [31:0]   r_ram1 [N];
    logic [31:0]   r_ram2 [N];
    logic [31:0]   r_ram3 [N];

    logic [31:0]   r_rd0, r_rd1, r_rd2, r_rd3;
    logic [1:0]    r_wsel;
    logic [31:0]   r_rdata;

    logic          w_match;
    logic          w_elig;
    logic          w_full;
    logic          w_wr;
    logic [23:0]   w_ts24;
    logic [31:0]   w_word;

`ifdef QCMD_CAPTURE_FILTER_EN
    assign w_match = ((bus.cmda & bus.cmda_mask) == bus.cmda_match);
`else
    assign w_match = 1'b1;
`endif

    // trig takes priority: a strobe coinciding with trig is never eligible
    assign w_elig = bus.cstrobe & r_armed & ~bus.trig & w_match;
    assign w_full = (r_ncap == NFULL);
    assign w_wr   = w_elig & ~w_full;
    assign w_ts24 = 24'(r_ts);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_wptr     <= '0;
            r_ncap     <= '0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_ts <= bus.trig ? '0 : r_ts + 1'b1;
            if (bus.trig) begin
                r_wptr     <= '0;
                r_ncap     <= '0;
                r_overflow <= 1'b0;
                r_armed    <= 1'b1;
            end else if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
                r_ncap <= r_ncap + 1'b1;
            end else if (w_elig) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset so it maps onto dual-port RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ram0[r_wptr] <= {w_ts24, bus.cmda};
            r_ram1[r_wptr] <= bus.command[63:32];
            r_ram2[r_wptr] <= bus.command[31:0];
            r_ram3[r_wptr] <= bus.extra;
        end
        r_rd0 <= r_ram0[bus.raddr[aw-1:2]];
        r_rd1 <= r_ram1[bus.raddr[aw-1:2]];
        r_rd2 <= r_ram2[bus.raddr[aw-1:2]];
        r_rd3 <= r_ram3[bus.raddr[aw-1:2]];
    end

    always_comb begin
        w_word = r_rd0;
        unique case (r_wsel)
            2'd0: w_word = r_rd0;
            2'd1: w_word = r_rd1;
            2'd2: w_word = r_rd2;
            2'd3: w_word = r_rd3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wsel  <= '0;
            r_rdata <= '0;
        end else begin
            r_wsel  <= bus.raddr[1:0];
            r_rdata <= w_word;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.ncap     = r_ncap;
    assign bus.overflow = r_overflow;
    assign bus.armed    = r_armed;
endmodule

// File: tb/tb_qcmd_capture.sv
// Directed self-checking bench for qcmd_capture (aw=4, N=4 entries).
// Define QCMD_CAPTURE_FILTER_EN to also exercise the cmda filter.
module tb_qcmd_capture;
    localparam int unsigned AW = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    qcmd_capture_if #(.aw(AW)) bus ();

    qcmd_capture #(.aw(AW), .tw(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] a, input logic [63:0] c, input logic [31:0] x);
        bus.cstrobe = 1'b1;
        bus.cmda    = a;
        bus.command = c;
        bus.extra   = x;
        cyc();
        bus.cstrobe = 1'b0;
    endtask

    task automatic trig_pulse();
        bus.trig = 1'b1;
        cyc();
        bus.trig = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
        bus.raddr = a;
        cyc();
        cyc();
        d = bus.rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++;
        if (bus.armed !== 1'b0) begin fails++; $display("FAIL reset_armed got %b exp 0", bus.armed); end
        tests++;
        if (bus.ncap !== 3'd0) begin fails++; $display("FAIL reset_ncap got %0d exp 0", bus.ncap); end
        tests++;
        if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
        tests++;
        if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 00000000", bus.rdata); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [31:0] d;
        trig_pulse();
        repeat (4) cyc();
        strobe(8'h03, 64'h1111_2222_3333_4444, 32'hAA);
        repeat (3) cyc();
        strobe(8'h05, 64'h1111_2222_3333_4444, 32'hAA);
        tests++;
        if (bus.ncap !== 3'd2) begin fails++; $display("FAIL basic_ncap got %0d exp 2", bus.ncap); end
        tests++;
        if (bus.armed !== 1'b1) begin fails++; $display("FAIL basic_armed got %b exp 1", bus.armed); end
        rd(4'd0, d);
        tests++;
        if (d !== 32'h0000_0403) begin fails++; $display("FAIL basic_w0e0 got %h exp 00000403", d); end
        rd(4'd4, d);
        tests++;
        if (d !== 32'h0000_0805) begin fails++; $display("FAIL basic_w0e1 got %h exp 00000805", d); end
        rd(4'd1, d);
        tests++;
        if (d !== 32'h1111_2222) begin fails++; $display("FAIL basic_w1 got %h exp 11112222", d); end
        rd(4'd2, d);
        tests++;
        if (d !== 32'h3333_4444) begin fails++; $display("FAIL basic_w2 got %h exp 33334444", d); end
        rd(4'd3, d);
        tests++;
        if (d !== 32'h0000_00AA) begin fails++; $display("FAIL basic_w3 got %h exp 000000aa", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        trig_pulse();
        for (int k = 1; k <= 6; k++) begin
            strobe(8'h20 + 8'(k), {32'hC0DE_0000 + 32'(k), 32'hF00D_0000 + 32'(k)}, 32'(k));
        end
        tests++;
        if (bus.ncap !== 3'd4) begin fails++; $display("FAIL ovf_ncap got %0d exp 4", bus.ncap); end
        tests++;
        if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
        rd(4'd0, d);
        tests++;
        if (d !== 32'h0000_0021) begin fails++; $display("FAIL ovf_e0w0 got %h exp 00000021", d); end
        rd(4'd4, d);
        tests++;
        if (d !== 32'h0000_0122) begin fails++; $display("FAIL ovf_e1w0 got %h exp 00000122", d); end
        rd(4'd8, d);
        tests++;
        if (d !== 32'h0000_0223) begin fails++; $display("FAIL ovf_e2w0 got %h exp 00000223", d); end
        rd(4'd12, d);
        tests++;
        if (d !== 32'h0000_0324) begin fails++; $display("FAIL ovf_e3w0 got %h exp 00000324", d); end
        rd(4'd13, d);
        tests++;
        if (d !== 32'hC0DE_0004) begin fails++; $display("FAIL ovf_e3w1 got %h exp c0de0004", d); end
        rd(4'd3, d);
        tests++;
        if (d !== 32'h0000_0001) begin fails++; $display("FAIL ovf_e0w3 got %h exp 00000001", d); end
    endtask

    task automatic test_second_trig();
        logic [31:0] d;
        trig_pulse();
        tests++;
        if (bus.ncap !== 3'd0) begin fails++; $display("FAIL retrig_ncap got %0d exp 0", bus.ncap); end
        tests++;
        if (bus.overflow !== 1'b0) begin fails++; $display("FAIL retrig_ovf got %b exp 0", bus.overflow); end
        repeat (2) cyc();
        strobe(8'h77, 64'hDEAD_BEEF_0000_0001, 32'h55);
        tests++;
        if (bus.ncap !== 3'd1) begin fails++; $display("FAIL retrig_ncap1 got %0d exp 1", bus.ncap); end
        rd(4'd0, d);
        tests++;
        if (d !== 32'h0000_0277) begin fails++; $display("FAIL retrig_e0w0 got %h exp 00000277", d); end
    endtask

    task automatic test_unarmed();
        logic [31:0] d;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        strobe(8'h99, 64'h0, 32'h0);
        tests++;
        if (bus.armed !== 1'b0) begin fails++; $display("FAIL unarmed_armed got %b exp 0", bus.armed); end
        tests++;
        if (bus.ncap !== 3'd0) begin fails++; $display("FAIL unarmed_ncap got %0d exp 0", bus.ncap); end
        tests++;
        if (bus.overflow !== 1'b0) begin fails++; $display("FAIL unarmed_ovf got %b exp 0", bus.overflow); end
        bus.trig = 1'b1;
        strobe(8'h98, 64'h0, 32'h0);
        bus.trig = 1'b0;
        tests++;
        if (bus.ncap !== 3'd0) begin fails++; $display("FAIL trigstrobe_ncap got %0d exp 0", bus.ncap); end
        tests++;
        if (bus.armed !== 1'b1) begin fails++; $display("FAIL trigstrobe_armed got %b exp 1", bus.armed); end
        rd(4'd0, d);
        tests++;
        if (d !== 32'h0000_0277) begin fails++; $display("FAIL unarmed_ram got %h exp 00000277", d); end
    endtask

    task automatic test_async_rst();
        logic [31:0] d;
        trig_pulse();
        strobe(8'h41, 64'h1, 32'h1);
        strobe(8'h42, 64'h2, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.ncap !== 3'd0) begin fails++; $display("FAIL arst_ncap got %0d exp 0", bus.ncap); end
        tests++;
        if (bus.armed !== 1'b0) begin fails++; $display("FAIL arst_armed got %b exp 0", bus.armed); end
        tests++;
        if (bus.rdata !== 32'h0) begin fails++; $display("FAIL arst_rdata got %h exp 00000000", bus.rdata); end
        #1;
        rst = 1'b0;
        cyc();
        rd(4'd4, d);
        tests++;
        if (d !== 32'h0000_0142) begin fails++; $display("FAIL arst_keep got %h exp 00000142", d); end
        trig_pulse();
        cyc();
        strobe(8'h51, 64'h3, 32'h3);
        tests++;
        if (bus.ncap !== 3'd1) begin fails++; $display("FAIL arst_recap_ncap got %0d exp 1", bus.ncap); end
        rd(4'd0, d);
        tests++;
        if (d !== 32'h0000_0151) begin fails++; $display("FAIL arst_recap got %h exp 00000151", d); end
    endtask

`ifdef QCMD_CAPTURE_FILTER_EN
    task automatic test_filter();
        logic [31:0] d;
        bus.cmda_mask  = 8'hF0;
        bus.cmda_match = 8'h10;
        trig_pulse();
        strobe(8'h12, 64'h12, 32'h12);
        strobe(8'h22, 64'h22, 32'h22);
        strobe(8'h1F, 64'h1F, 32'h1F);
        tests++;
        if (bus.ncap !== 3'd2) begin fails++; $display("FAIL filt_ncap got %0d exp 2", bus.ncap); end
        rd(4'd0, d);
        tests++;
        if (d !== 32'h0000_0012) begin fails++; $display("FAIL filt_e0 got %h exp 00000012", d); end
        rd(4'd4, d);
        tests++;
        if (d !== 32'h0000_021F) begin fails++; $display("FAIL filt_e1 got %h exp 0000021f", d); end
        bus.cmda_mask  = 8'h00;
        bus.cmda_match = 8'h00;
    endtask
`endif

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        bus.trig    = 1'b0;
        bus.cstrobe = 1'b0;
        bus.command = '0;
        bus.cmda    = '0;
        bus.extra   = '0;
        bus.raddr   = '0;
`ifdef QCMD_CAPTURE_FILTER_EN
        bus.cmda_mask  = 8'h00;
        bus.cmda_match = 8'h00;
`endif
        test_reset();
        test_basic();
        test_overflow();
        test_second_trig();
        test_unarmed();
        test_async_rst();
`ifdef QCMD_CAPTURE_FILTER_EN
        test_filter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
